// File: rtl/tcp_vlg_pkg.sv
// Shared types and constants for the TCP engine blocks.
// Holds the receive-buffer state encoding and the width of its drop counter.
package tcp_vlg_pkg;

    typedef enum logic [1:0] {
        RXB_IDLE,
        RXB_ACTIVE,
        RXB_DRAIN
    } rx_buf_state_t;

    localparam int RXB_DROP_CNT_W = 16;

endpackage

// File: rtl/tcp_vlg_rx_buf_ram.sv
// Simple dual-port byte RAM for the receive buffer.
// One write port and one read port with a single cycle of read latency.
module tcp_vlg_rx_buf_ram #(
    parameter int DEPTH = 12
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    input  logic [DEPTH-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [0:(1<<DEPTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tcp_vlg_rx_buf.sv
// Receive payload buffer between the TCP engine and user logic.
// Absorbs the non-stallable byte stream into a ring and serves it over valid/ready.
module tcp_vlg_rx_buf
    import tcp_vlg_pkg::*;
#(
    parameter int DEPTH  = 12,
    parameter int AF_THR = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      connected,
    input  logic [7:0]                in_d,
    input  logic                      in_v,
    output logic [7:0]                out_d,
    output logic                      out_v,
    input  logic                      out_rdy,
    output logic [DEPTH:0]            free,
    output logic                      almost_full,
    output logic                      overflow,
    output logic [RXB_DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [DEPTH:0] CAP    = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] AF_LIM = (DEPTH+1)'(AF_THR);

    rx_buf_state_t  state;
    logic           connected_q;
    logic [DEPTH:0] wr_ptr;
    logic [DEPTH:0] rd_ptr;
    logic [DEPTH:0] used;
    logic [DEPTH:0] free_c;
    logic           rd_pend;
    logic           skid_v;
    logic [7:0]     skid_d;
    logic [7:0]     ram_q;
    logic           conn_rise;
    logic           conn_fall;
    logic           empty;
    logic           full;
    logic           flush;
    logic           wr_en;
    logic           drop;
    logic           consume;
    logic           rd_en;
    logic [1:0]     occ_next;

    assign conn_rise = connected & ~connected_q;
    assign conn_fall = ~connected & connected_q;
    assign used      = wr_ptr - rd_ptr;
    assign free_c    = CAP - used;
    assign empty     = (used == '0);
    assign full      = (used == CAP);
    assign flush     = conn_rise && (state != RXB_ACTIVE);
    assign wr_en     = (state == RXB_ACTIVE) && in_v && !full;
    assign drop      = (state == RXB_ACTIVE) && in_v && full;
    assign consume   = out_v & out_rdy;

    // Fetch only while the two-entry stage can still absorb what is in flight.
    assign occ_next  = 2'(out_v) + 2'(skid_v) + 2'(rd_pend) - 2'(consume);
    assign rd_en     = (state != RXB_IDLE) && !flush && !empty && (occ_next < 2'd2);

    tcp_vlg_rx_buf_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[DEPTH-1:0]),
        .wr_data (in_d),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[DEPTH-1:0]),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RXB_IDLE;
            connected_q <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_pend     <= 1'b0;
            skid_v      <= 1'b0;
            skid_d      <= '0;
            out_v       <= 1'b0;
            out_d       <= '0;
            free        <= CAP;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            connected_q <= connected;
            free        <= free_c;
            almost_full <= (free_c < AF_LIM);

            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                rd_pend  <= 1'b0;
                skid_v   <= 1'b0;
                out_v    <= 1'b0;
                overflow <= 1'b0;
                drop_cnt <= '0;
                state    <= RXB_ACTIVE;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != '1) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                rd_pend <= rd_en;

                // The output register refills from the skid first, then from RAM.
                if (!out_v || consume) begin
                    if (skid_v) begin
                        out_d  <= skid_d;
                        out_v  <= 1'b1;
                        skid_v <= rd_pend;
                        if (rd_pend) begin
                            skid_d <= ram_q;
                        end
                    end else if (rd_pend) begin
                        out_d <= ram_q;
                        out_v <= 1'b1;
                    end else begin
                        out_v <= 1'b0;
                    end
                end else if (rd_pend) begin
                    skid_d <= ram_q;
                    skid_v <= 1'b1;
                end

                case (state)
                    RXB_ACTIVE: begin
                        if (conn_fall) begin
                            state <= RXB_DRAIN;
                        end
                    end
                    RXB_DRAIN: begin
                        if (empty && !rd_pend && !out_v && !skid_v) begin
                            state <= RXB_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tcp_vlg_rx_buf.sv
// Self-checking bench for tcp_vlg_rx_buf: a table for the basic stream,
// then directed sequences for backpressure, overflow, drain, flush and reset.
module tb_tcp_vlg_rx_buf;
    import tcp_vlg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        connected;
    logic [7:0]  in_d;
    logic        in_v;
    logic [7:0]  out_d;
    logic        out_v;
    logic        out_rdy;
    logic [12:0] free;
    logic        almost_full;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       conn;
        logic       in_v;
        logic [7:0] in_d;
        logic       rdy;
        logic       exp_v;
        logic [7:0] exp_d;
        int         exp_free;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    tcp_vlg_rx_buf #(
        .DEPTH  (12),
        .AF_THR (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .connected   (connected),
        .in_d        (in_d),
        .in_v        (in_v),
        .out_d       (out_d),
        .out_v       (out_v),
        .out_rdy     (out_rdy),
        .free        (free),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic v, input logic [7:0] d, input logic r);
        connected = c;
        in_v      = v;
        in_d      = d;
        out_rdy   = r;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic writeBytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, base + 8'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // Drain with out_rdy high for a fixed window, expecting base, base+1, ...
    task automatic collect(input int n_exp, input logic [7:0] base, input int budget, input string name);
        int got;
        logic [7:0] exp_b;
        got = 0;
        out_rdy = 1'b1;
        in_v    = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (out_v) begin
                exp_b = base + 8'(got);
                checkOutput(name, int'(out_d), int'(exp_b));
                got++;
            end
            tick();
        end
        checkOutput({name, "_count"}, got, n_exp);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;

        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4096};
        vecs[1]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 4096};
        vecs[2]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 4095};
        vecs[3]  = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 8'h00, 4095};
        vecs[4]  = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 8'h01, 4095};
        vecs[5]  = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 8'h02, 4095};
        vecs[6]  = '{1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 8'h03, 4095};
        vecs[7]  = '{1'b1, 1'b1, 8'h06, 1'b1, 1'b1, 8'h04, 4095};
        vecs[8]  = '{1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 8'h05, 4095};
        vecs[9]  = '{1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 8'h06, 4095};
        vecs[10] = '{1'b1, 1'b1, 8'h09, 1'b1, 1'b1, 8'h07, 4095};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 4095};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h09, 4096};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4096};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4096};

        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput("rst_out_v", int'(out_v), 0);
        checkOutput("rst_out_d", int'(out_d), 0);
        checkOutput("rst_free", int'(free), 4096);
        checkOutput("rst_almost_full", int'(almost_full), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_drop_cnt", int'(drop_cnt), 0);
        rst = 1'b1;
        tick();
        tick();

        // Basic stream: first byte appears three cycles after its in_v.
        for (int v = 0; v < 15; v++) begin
            applyStimulus(vecs[v].conn, vecs[v].in_v, vecs[v].in_d, vecs[v].rdy);
            tick();
            checkOutput($sformatf("basic_out_v[%0d]", v), int'(out_v), int'(vecs[v].exp_v));
            if (vecs[v].exp_v) begin
                checkOutput($sformatf("basic_out_d[%0d]", v), int'(out_d), int'(vecs[v].exp_d));
            end
            checkOutput($sformatf("basic_free[%0d]", v), int'(free), vecs[v].exp_free);
            checkOutput($sformatf("basic_af[%0d]", v), int'(almost_full), 0);
        end

        // Backpressure: two bytes prefetch into the output stage, so 4098 fill it.
        writeBytes(4098, 8'h00);
        tick();
        tick();
        checkOutput("bp_free", int'(free), 0);
        checkOutput("bp_almost_full", int'(almost_full), 1);
        checkOutput("bp_overflow", int'(overflow), 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput("ovf_drop_cnt", int'(drop_cnt), 5);
        checkOutput("ovf_overflow", int'(overflow), 1);
        checkOutput("ovf_free", int'(free), 0);

        collect(4098, 8'h00, 4200, "bp_data");
        checkOutput("bp_free_after", int'(free), 4096);
        checkOutput("bp_af_after", int'(almost_full), 0);

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("ovf_sticky", int'(overflow), 1);
        checkOutput("idle_state", int'(dut.state), int'(RXB_IDLE));
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("reconn_overflow", int'(overflow), 0);
        checkOutput("reconn_drop_cnt", int'(drop_cnt), 0);

        // Disconnect drain: bytes arriving after the disconnect are neither stored nor counted.
        writeBytes(20, 8'h80);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
            tick();
        end
        collect(20, 8'h80, 60, "drain_data");
        checkOutput("drain_state", int'(dut.state), int'(RXB_IDLE));
        checkOutput("drain_drop_cnt", int'(drop_cnt), 0);
        checkOutput("drain_overflow", int'(overflow), 0);
        checkOutput("drain_free", int'(free), 4096);

        // Reconnect flush from DRAIN with about 50 bytes still buffered.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        writeBytes(60, 8'h40);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("flush_pre_state", int'(dut.state), int'(RXB_DRAIN));
        checkOutput("flush_pre_out_v", int'(out_v), 1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("flush_out_v", int'(out_v), 0);
        tick();
        tick();
        checkOutput("flush_free", int'(free), 4096);
        writeBytes(5, 8'hA0);
        collect(5, 8'hA0, 30, "flush_data");

        // Reset mid-stream with 100 bytes buffered and out_v high.
        writeBytes(100, 8'h01);
        tick();
        tick();
        checkOutput("mid_pre_out_v", int'(out_v), 1);
        checkOutput("mid_pre_out_d", int'(out_d), 1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_out_v", int'(out_v), 0);
        checkOutput("mid_rst_out_d", int'(out_d), 0);
        checkOutput("mid_rst_free", int'(free), 4096);
        checkOutput("mid_rst_af", int'(almost_full), 0);
        checkOutput("mid_rst_overflow", int'(overflow), 0);
        checkOutput("mid_rst_drop_cnt", int'(drop_cnt), 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h77, 1'b1);
            tick();
            if (out_v) begin
                seen++;
            end
        end
        checkOutput("mid_post_no_out_v", seen, 0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        writeBytes(3, 8'h11);
        collect(3, 8'h11, 20, "mid_new_data");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
